store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Post-commit store buffer between the MEM stage and the single-port data memory.
- Committed stores are queued here and drained to memory when the port is idle, so a store never stalls the pipeline unless the buffer is full.
- Loads in MEM search the buffer and receive the youngest matching store's data the same cycle (store-to-load forwarding), so a load never reads stale memory.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: byte address width.
- DATA_W, 32: store/load data width; full-word accesses only.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous and active-high.
- i_st_valid  input  1  committed store from MEM stage.
- i_st_addr  input  ADDR_W  store byte address.
- i_st_data  input  DATA_W  store data.
- o_st_ready  output  1  buffer can accept a store this cycle.
- i_ld_valid  input  1  load in MEM stage.
- i_ld_addr  input  ADDR_W  load byte address.
- o_ld_hit  output  1  load matches a buffered store.
- o_ld_data  output  DATA_W  forwarded data; valid when o_ld_hit.
- o_ld_stall  output  1  load missed but the memory port is busy draining.
- o_mem_wr_en  output  1  drain write request.
- o_mem_addr  output  ADDR_W  drain address.
- o_mem_wdata  output  DATA_W  drain data.
- i_mem_ready  input  1  memory accepts the write this cycle.
- o_count  output  $clog2(DEPTH)+1  occupancy.
- o_empty  output  1  o_count == 0.

Behaviour:
- Reset: head=0, tail=0, count=0, drain FSM=IDLE, all entries invalid.
- Reset output values: o_st_ready=1, o_mem_wr_en=0, o_mem_addr=0, o_mem_wdata=0, o_ld_hit=0, o_ld_data=0, o_ld_stall=0, o_count=0, o_empty=1.
- Reset asserted mid-drain discards all entries; no write completes.
- Storage: circular FIFO of {addr[ADDR_W-1:2], data}. Address compares ignore bits [1:0].
- Enqueue:
  - Fires when i_st_valid && o_st_ready. Entry written at tail; tail wraps at DEPTH; count+1.
  - o_st_ready = (count < DEPTH). No same-cycle pass-through when full, even if a drain pops that cycle.
  - i_st_valid while not ready: the store is dropped; the pipeline must stall on !o_st_ready.
- Drain FSM:
  - IDLE -> BUSY when count>0 && (!i_ld_valid || count==DEPTH). Loads have port priority unless the buffer is full.
  - BUSY: o_mem_wr_en=1, o_mem_addr/o_mem_wdata = head entry, registered and held stable.
  - BUSY with i_mem_ready=1: pop head, head wraps, count-1. Go to IDLE if the remaining count is 0 or i_ld_valid; otherwise stay BUSY with the next head registered.
  - Once asserted, o_mem_wr_en is never retracted before i_mem_ready.
- Load lookup:
  - Combinational, zero latency.
  - o_ld_hit = i_ld_valid && any valid entry matches, including the entry currently being drained.
  - When several entries match, o_ld_data comes from the youngest, i.e. the closest to tail.
  - o_ld_hit=0 implies o_ld_data=0.
- o_ld_stall = i_ld_valid && !o_ld_hit && o_mem_wr_en.
- Simultaneous enqueue and pop: count unchanged.
- i_st_valid && i_ld_valid in the same cycle: the store is enqueued, and the lookup sees only entries present before the edge.
- Stores to the same address stay as separate entries; there is no merging.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, the entry struct {addr_word, data}, and the drain state enum {IDLE, BUSY}.
- One natural sub-module, store_buffer_match: a priority search over the valid vector, age-ordered from tail, returning hit and the youngest data.

Test Plan:
- Reset mid-BUSY with 3 entries -> o_count=0, o_mem_wr_en=0 immediately; the next store lands at index 0.
- Store 0x100=0xAAAA, then load 0x102 next cycle before drain -> o_ld_hit=1, o_ld_data=0xAAAA.
- Stores 0x40=1, 0x40=2, 0x40=3, then load 0x40 -> o_ld_data=3. After all drain, memory writes occur in order 1, 2, 3, and load 0x40 gives o_ld_hit=0.
- Fill 4 stores with i_ld_valid held high and i_mem_ready=0 -> o_st_ready=0, drain starts despite the load, o_mem_wr_en stays high until i_mem_ready. A 5th store is accepted only the cycle after the pop.
- BUSY draining 0x200, load 0x300 misses -> o_ld_stall=1 until i_mem_ready. Then FSM goes IDLE and o_ld_stall=0.
- Enqueue and pop in the same cycle at count=2 -> count stays 2. Tail and head both wrap correctly across 10 such cycles.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types for the post-commit store buffer.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  // One buffered store: word address (byte offset bits dropped) and data.
  typedef struct packed {
    logic [SB_ADDR_W-3:0] addr_word;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  // Drain engine: IDLE leaves the memory port to loads, BUSY owns it.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } drain_state_t;

endpackage

// File: rtl/store_buffer_match.sv
// Age-ordered address search over the buffered stores; youngest match wins.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module store_buffer_match #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 30,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]                 i_vld,
  input  logic [DEPTH-1:0][WORD_W-1:0]     i_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]     i_data,
  input  logic [$clog2(DEPTH)-1:0]         i_tail,
  input  logic [WORD_W-1:0]                i_key,
  output logic                             o_hit,
  output logic [DATA_W-1:0]                o_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest (tail-DEPTH .. tail-1) so a later match overrides.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    idx    = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = i_tail - PTR_W'(k);
      if (i_vld[idx] && (i_addr[idx] == i_key)) begin
        o_hit  = 1'b1;
        o_data = i_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: queues stores, drains to memory, forwards to loads.
// Latency: enqueue one cycle; load forwarding combinational; drain starts the cycle after the port frees.
// Backpressure: o_st_ready drops when full; drain write is held until i_mem_ready.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_st_valid,
  input  logic [ADDR_W-1:0]        i_st_addr,
  input  logic [DATA_W-1:0]        i_st_data,
  output logic                     o_st_ready,
  input  logic                     i_ld_valid,
  input  logic [ADDR_W-1:0]        i_ld_addr,
  output logic                     o_ld_hit,
  output logic [DATA_W-1:0]        o_ld_data,
  output logic                     o_ld_stall,
  output logic                     o_mem_wr_en,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  input  logic                     i_mem_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WORD_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][WORD_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             vld_q;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;

  drain_state_t                 state;
  drain_state_t                 state_nxt;
  logic                         load_reg;
  logic [PTR_W-1:0]             load_idx;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [DATA_W-1:0]            mem_wdata_q;

  logic                         push;
  logic                         pop;
  logic                         match_hit;
  logic [DATA_W-1:0]            match_data;
  logic                         unused_addr_lsbs;

  assign o_st_ready = (count < FULL_CNT);
  assign push       = i_st_valid && o_st_ready;
  assign pop        = (state == BUSY) && i_mem_ready;

  // Drain decision: loads own the port unless the buffer is full.
  always_comb begin
    state_nxt = state;
    load_reg  = 1'b0;
    load_idx  = head;
    case (state)
      IDLE: begin
        if ((count != '0) && (!i_ld_valid || (count == FULL_CNT))) begin
          state_nxt = BUSY;
          load_reg  = 1'b1;
        end
      end
      BUSY: begin
        if (i_mem_ready) begin
          if ((count == CNT_W'(1)) || i_ld_valid) begin
            state_nxt = IDLE;
          end else begin
            load_reg = 1'b1;
            load_idx = head + PTR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Circular queue storage, pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q <= '0;
      data_q <= '0;
      vld_q  <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_q[tail] <= i_st_addr[ADDR_W-1:2];
        data_q[tail] <= i_st_data;
        vld_q[tail]  <= 1'b1;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered drain write; held stable while memory stalls, cleared when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (load_reg) begin
      mem_addr_q  <= {addr_q[load_idx], 2'b00};
      mem_wdata_q <= data_q[load_idx];
    end else if (state_nxt == IDLE) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .DATA_W (DATA_W)
  ) u_match (
    .i_vld  (vld_q),
    .i_addr (addr_q),
    .i_data (data_q),
    .i_tail (tail),
    .i_key  (i_ld_addr[ADDR_W-1:2]),
    .o_hit  (match_hit),
    .o_data (match_data)
  );

  assign o_ld_hit    = i_ld_valid && match_hit;
  assign o_ld_data   = o_ld_hit ? match_data : '0;
  assign o_mem_wr_en = (state == BUSY);
  assign o_ld_stall  = i_ld_valid && !o_ld_hit && o_mem_wr_en;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_count     = count;
  assign o_empty     = (count == '0);

  // Byte-offset bits are irrelevant for full-word accesses.
  assign unused_addr_lsbs = &{1'b0, i_st_addr[1:0], i_ld_addr[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, forwarding, drain order, full-buffer and stall cases.
// Latency: inputs driven on the falling edge, outputs sampled after it.
// Backpressure: i_mem_ready driven directly by the stimulus.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic            clk;
  logic            rst;
  logic            st_valid;
  logic [AW-1:0]   st_addr;
  logic [DW-1:0]   st_data;
  logic            st_ready;
  logic            ld_valid;
  logic [AW-1:0]   ld_addr;
  logic            ld_hit;
  logic [DW-1:0]   ld_data;
  logic            ld_stall;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ready;
  logic [2:0]      count;
  logic            empty;

  int n_tests = 0;
  int n_fail  = 0;

  sb_entry_t wlog[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_st_valid  (st_valid),
    .i_st_addr   (st_addr),
    .i_st_data   (st_data),
    .o_st_ready  (st_ready),
    .i_ld_valid  (ld_valid),
    .i_ld_addr   (ld_addr),
    .o_ld_hit    (ld_hit),
    .o_ld_data   (ld_data),
    .o_ld_stall  (ld_stall),
    .o_mem_wr_en (mem_wr_en),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ready (mem_ready),
    .o_count     (count),
    .o_empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: record every write that completes on this edge.
  always @(posedge clk) begin
    if (!rst && mem_wr_en && mem_ready)
      wlog.push_back('{addr_word: mem_addr[AW-1:2], data: mem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drain_all();
    st_valid  = 1'b0;
    ld_valid  = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 40 && !(empty && !mem_wr_en); i++) step();
    chk("drain_done", {63'd0, empty && !mem_wr_en}, 64'd1);
    mem_ready = 1'b0;
  endtask

  task automatic chk_log(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (idx < wlog.size()) begin
      chk("log_addr", {wlog[idx].addr_word, 2'b00}, a);
      chk("log_data", wlog[idx].data, d);
    end else begin
      chk("log_missing", idx, wlog.size());
    end
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
    step(); step();

    // Reset values
    chk("rst_st_ready", st_ready, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    rst = 1'b0;
    step();

    // Reset while BUSY with three entries
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h11; step();
    st_addr = 32'h14; st_data = 32'h22; step();
    st_addr = 32'h18; st_data = 32'h33; step();
    st_valid = 1'b0;
    chk("mid_count", count, 3);
    chk("mid_wr_en", mem_wr_en, 1);
    chk("mid_addr", mem_addr, 32'h10);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_wr_en", mem_wr_en, 0);
    chk("arst_empty", empty, 1);
    chk("arst_addr", mem_addr, 0);
    step();
    rst = 1'b0;
    wlog.delete();
    st_valid = 1'b1; st_addr = 32'h500; st_data = 32'h55; step();
    st_valid = 1'b0; step();
    chk("post_rst_addr", mem_addr, 32'h500);
    chk("post_rst_data", mem_wdata, 32'h55);
    drain_all();
    chk("post_rst_log_len", wlog.size(), 1);
    chk_log(0, 32'h500, 32'h55);

    // Forward to a load with a different byte offset
    wlog.delete();
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hAAAA; step();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h102; #1;
    chk("fwd_hit", ld_hit, 1);
    chk("fwd_data", ld_data, 32'hAAAA);
    chk("fwd_stall", ld_stall, 0);
    chk("fwd_wr_en", mem_wr_en, 0);
    step();
    drain_all();

    // Same-address stores: youngest forwards, drains in order
    wlog.delete();
    st_valid = 1'b1; st_addr = 32'h40;
    for (int i = 1; i <= 3; i++) begin
      st_data = DW'(i); step();
    end
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h40; #1;
    chk("young_hit", ld_hit, 1);
    chk("young_data", ld_data, 3);
    drain_all();
    chk("young_log_len", wlog.size(), 3);
    for (int i = 0; i < 3; i++) chk_log(i, 32'h40, DW'(i + 1));
    ld_valid = 1'b1; ld_addr = 32'h40; #1;
    chk("drained_hit", ld_hit, 0);
    chk("drained_data", ld_data, 0);
    ld_valid = 1'b0;

    // Fill with a load held high: full forces drain, overflow store dropped
    wlog.delete();
    ld_valid = 1'b1; ld_addr = 32'h900; st_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_addr = AW'(32'h80 + 4 * i); st_data = DW'(32'hA0 + i); step();
    end
    chk("full_count", count, 4);
    chk("full_st_ready", st_ready, 0);
    chk("full_wr_en_wait", mem_wr_en, 0);
    st_addr = 32'h90; st_data = 32'hA4; step();
    chk("full_wr_en", mem_wr_en, 1);
    chk("full_mem_addr", mem_addr, 32'h80);
    chk("full_stall", ld_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_wr_en", mem_wr_en, 1);
      chk("full_hold_count", count, 4);
    end
    mem_ready = 1'b1; step();
    chk("pop_count", count, 3);
    chk("pop_wr_en", mem_wr_en, 0);
    chk("pop_st_ready", st_ready, 1);
    mem_ready = 1'b0; step();
    chk("refill_count", count, 4);
    drain_all();
    chk("full_log_len", wlog.size(), 5);
    for (int i = 0; i < 5; i++) chk_log(i, AW'(32'h80 + 4 * i), DW'(32'hA0 + i));

    // Load miss while draining stalls until the write completes
    wlog.delete();
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'h2; step();
    st_valid = 1'b0; step();
    chk("busy_wr_en", mem_wr_en, 1);
    chk("busy_addr", mem_addr, 32'h200);
    ld_valid = 1'b1; ld_addr = 32'h200; #1;
    chk("drain_fwd_hit", ld_hit, 1);
    chk("drain_fwd_data", ld_data, 2);
    chk("drain_fwd_stall", ld_stall, 0);
    ld_addr = 32'h300; #1;
    chk("miss_hit", ld_hit, 0);
    chk("miss_stall", ld_stall, 1);
    step();
    chk("miss_stall_hold", ld_stall, 1);
    mem_ready = 1'b1; #1;
    chk("miss_stall_ready", ld_stall, 1);
    step();
    mem_ready = 1'b0; #1;
    chk("miss_stall_clear", ld_stall, 0);
    chk("miss_wr_en_clear", mem_wr_en, 0);
    chk("miss_empty", empty, 1);
    ld_valid = 1'b0;
    chk("miss_log_len", wlog.size(), 1);

    // Steady push+pop at count 2 across pointer wraps
    wlog.delete();
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'h1000; step();
    st_addr = 32'h604; st_data = 32'h1001; step();
    st_valid = 1'b0;
    chk("pp_count0", count, 2);
    chk("pp_addr0", mem_addr, 32'h600);
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1; st_addr = AW'(32'h600 + 4 * (k + 2)); st_data = DW'(32'h1000 + k + 2);
      mem_ready = 1'b1; #1;
      chk("pp_count", count, 2);
      chk("pp_addr", mem_addr, AW'(32'h600 + 4 * k));
      chk("pp_data", mem_wdata, DW'(32'h1000 + k));
      step();
    end
    st_valid = 1'b0; mem_ready = 1'b0;
    chk("pp_count_end", count, 2);
    chk("pp_addr_end", mem_addr, 32'h628);
    drain_all();
    chk("pp_log_len", wlog.size(), 12);
    for (int j = 0; j < 12; j++) chk_log(j, AW'(32'h600 + 4 * j), DW'(32'h1000 + j));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
